// File: rtl/ysyx_25020047_lsu.sv
// ysyx_25020047_lsu: load/store unit between execute and register-file writeback.
// It takes one instruction at a time and runs a single bus transaction for it.
// It then returns a writeback packet that carries data, a write enable and an error flag.
module ysyx_25020047_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] inst_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        read,
    input  logic        write,
    input  logic        reg_wen,
    input  logic [4:0]  rd,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic        mem_req_wen,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_rdata,
    output logic        mem_resp_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_rd,
    output logic [31:0] out_data,
    output logic        out_wen,
    output logic        out_err
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_cnt;
    logic        r_is_lw;
    logic        r_is_lbu;
    logic [1:0]  r_off;
    logic        r_reg_wen;

    logic [31:0] r_req_addr;
    logic        r_req_wen;
    logic [31:0] r_req_wdata;
    logic [3:0]  r_req_wmask;

    logic [4:0]  r_out_rd;
    logic [31:0] r_out_data;
    logic        r_out_wen;
    logic        r_out_err;

    logic        w_is_lw;
    logic        w_is_lbu;
    logic        w_is_sw;
    logic        w_is_sb;
    logic        w_mem;
    logic        w_known;
    logic        w_misalign;
    logic        w_go_req;
    logic        w_timeout;
    logic [7:0]  w_byte;

    // Decode the incoming instruction; only meaningful while IDLE.
    always_comb begin
        w_is_lw    = (inst_type == 32'h20);
        w_is_lbu   = (inst_type == 32'h40);
        w_is_sw    = (inst_type == 32'h80);
        w_is_sb    = (inst_type == 32'h160);
        w_mem      = read | write;
        w_known    = w_is_lw | w_is_lbu | w_is_sw | w_is_sb;
        w_misalign = w_mem & (w_is_lw | w_is_sw) & (addr[1:0] != 2'b00);
        w_go_req   = w_mem & w_known & ~w_misalign;
        w_timeout  = (r_cnt == TIMEOUT);
    end

    // Pick the addressed byte lane out of the returned word for lbu.
    always_comb begin
        case (r_off)
            2'd0:    w_byte = mem_resp_rdata[7:0];
            2'd1:    w_byte = mem_resp_rdata[15:8];
            2'd2:    w_byte = mem_resp_rdata[23:16];
            default: w_byte = mem_resp_rdata[31:24];
        endcase
    end

    // State register; reset wins over any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (in_valid) w_next = w_go_req ? REQ : DONE;
            REQ:  if (mem_req_ready) w_next = RESP;
            RESP: if (mem_resp_valid || w_timeout) w_next = DONE;
            DONE: if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state; data fields come from registers.
    always_comb begin
        in_ready       = (r_state == IDLE);
        mem_req_valid  = (r_state == REQ);
        mem_resp_ready = (r_state == RESP);
        out_valid      = (r_state == DONE);
        mem_req_addr   = r_req_addr;
        mem_req_wen    = r_req_wen;
        mem_req_wdata  = r_req_wdata;
        mem_req_wmask  = r_req_wmask;
        out_rd         = r_out_rd;
        out_data       = r_out_data;
        out_wen        = r_out_wen;
        out_err        = r_out_err;
    end

    // Latch the instruction, format the request and build the writeback packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_is_lw     <= 1'b0;
            r_is_lbu    <= 1'b0;
            r_off       <= 2'b00;
            r_reg_wen   <= 1'b0;
            r_req_addr  <= '0;
            r_req_wen   <= 1'b0;
            r_req_wdata <= '0;
            r_req_wmask <= '0;
            r_out_rd    <= '0;
            r_out_data  <= '0;
            r_out_wen   <= 1'b0;
            r_out_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_cnt     <= '0;
                    r_is_lw   <= w_is_lw;
                    r_is_lbu  <= w_is_lbu;
                    r_off     <= addr[1:0];
                    r_reg_wen <= reg_wen;
                    r_out_rd  <= rd;
                    if (w_go_req) begin
                        r_req_addr  <= {addr[31:2], 2'b00};
                        r_req_wen   <= w_is_sw | w_is_sb;
                        r_req_wdata <= w_is_sw ? wdata :
                                       w_is_sb ? {4{wdata[7:0]}} : 32'h0;
                        r_req_wmask <= w_is_sw ? 4'hF :
                                       w_is_sb ? (4'b0001 << addr[1:0]) : 4'h0;
                        r_out_data  <= '0;
                        r_out_wen   <= 1'b0;
                        r_out_err   <= 1'b0;
                    end else if (w_misalign) begin
                        r_out_data  <= '0;
                        r_out_wen   <= 1'b0;
                        r_out_err   <= 1'b1;
                    end else begin
                        // Non-memory op passes the ALU result through; a memory
                        // flag on an unknown op code is flagged as an error.
                        r_out_data  <= addr;
                        r_out_wen   <= w_mem ? 1'b0 : reg_wen;
                        r_out_err   <= w_mem;
                    end
                end
                REQ: if (mem_req_ready) r_cnt <= '0;
                RESP: begin
                    if (mem_resp_valid) begin
                        r_out_data <= r_is_lw  ? mem_resp_rdata :
                                      r_is_lbu ? {24'h0, w_byte} : 32'h0;
                        r_out_wen  <= (r_is_lw | r_is_lbu) & r_reg_wen;
                        r_out_err  <= 1'b0;
                    end else if (w_timeout) begin
                        r_out_data <= '0;
                        r_out_wen  <= 1'b0;
                        r_out_err  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// Directed testbench for ysyx_25020047_lsu with a scoreboard of writeback packets.
module tb_ysyx_25020047_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] inst_type = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic        reg_wen = 1'b0;
    logic [4:0]  rd = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_rdata = '0;
    logic        mem_resp_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic        out_wen;
    logic        out_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        wen;
        logic        err;
    } exp_t;

    exp_t sb_q[$];

    ysyx_25020047_lsu #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .inst_type(inst_type), .addr(addr), .wdata(wdata),
        .read(read), .write(write), .reg_wen(reg_wen), .rd(rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .mem_resp_ready(mem_resp_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rd(out_rd), .out_data(out_data), .out_wen(out_wen), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_req_valid"}, mem_req_valid, 0);
        chk({tag, "_resp_ready"}, mem_resp_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
    endtask

    // One instruction end to end. tie: ready/resp held high throughout.
    task automatic run_op(input string tag, input logic [31:0] ty, a, wd,
                          input logic rf, wf, rw, input logic [4:0] rdi,
                          input logic [31:0] rdata, input bit tie,
                          input int req_stall, input bit respond, input int out_stall,
                          input bit exp_bus, input logic exp_bwen,
                          input logic [3:0] exp_wmask, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_data, input logic exp_wen,
                          input logic exp_err, input int exp_lat);
        int   lat;
        int   reqc;
        exp_t e;
        exp_t got;
        chk({tag, "_in_ready_pre"}, in_ready, 1);
        mem_resp_rdata = rdata;
        mem_req_ready  = tie;
        mem_resp_valid = tie;
        inst_type = ty; addr = a; wdata = wd;
        read = rf; write = wf; reg_wen = rw; rd = rdi;
        in_valid = 1'b1;
        e.rd = rdi; e.data = exp_data; e.wen = exp_wen; e.err = exp_err;
        sb_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        reqc = 0;
        while (!out_valid && lat <= 40) begin
            chk({tag, "_in_ready_busy"}, in_ready, 0);
            if (mem_req_valid) begin
                chk({tag, "_req_valid"}, mem_req_valid, exp_bus);
                chk({tag, "_req_addr"}, mem_req_addr, {a[31:2], 2'b00});
                chk({tag, "_req_wen"}, mem_req_wen, exp_bwen);
                chk({tag, "_req_wmask"}, mem_req_wmask, exp_wmask);
                chk({tag, "_req_wdata"}, mem_req_wdata, exp_wdata);
                if (!tie) mem_req_ready = (reqc >= req_stall);
                reqc++;
            end else if (!tie) begin
                mem_req_ready = 1'b0;
            end
            if (!tie) mem_resp_valid = respond && mem_resp_ready;
            @(negedge clk);
            lat++;
        end
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        chk({tag, "_out_valid_seen"}, out_valid, 1);
        if (out_valid) begin
            chk({tag, "_latency"}, lat, exp_lat);
            chk({tag, "_bus_used"}, (reqc != 0), exp_bus);
            if (sb_q.size() == 0) begin
                chk({tag, "_sb_empty"}, 0, 1);
            end else begin
                got.rd = out_rd; got.data = out_data; got.wen = out_wen; got.err = out_err;
                e = sb_q.pop_front();
                for (int i = 0; i <= out_stall; i++) begin
                    chk({tag, "_out_valid"}, out_valid, 1);
                    chk({tag, "_out_rd"}, out_rd, e.rd);
                    chk({tag, "_out_data"}, out_data, e.data);
                    chk({tag, "_out_wen"}, out_wen, e.wen);
                    chk({tag, "_out_err"}, out_err, e.err);
                    chk({tag, "_in_ready_done"}, in_ready, 0);
                    if (i < out_stall) @(negedge clk);
                end
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk_idle({tag, "_after"});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        chk_idle("reset");
        chk("reset_out_data", out_data, 0);
        chk("reset_out_wen", out_wen, 0);
        chk("reset_out_err", out_err, 0);
        chk("reset_req_wmask", mem_req_wmask, 0);
        chk("reset_req_addr", mem_req_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        // lw with bus tied ready; the early response during acceptance must be ignored.
        run_op("lw", 32'h20, 32'h8000_0004, 32'h0, 1, 0, 1, 5'd5, 32'hDEAD_BEEF, 1,
               0, 1, 0, 1, 0, 4'h0, 32'h0, 32'hDEAD_BEEF, 1, 0, 3);
        // lbu lane selection.
        run_op("lbu7", 32'h40, 32'h8000_0007, 32'h0, 1, 0, 1, 5'd6, 32'h1234_5678, 0,
               0, 1, 0, 1, 0, 4'h0, 32'h0, 32'h0000_0012, 1, 0, 3);
        run_op("lbu4", 32'h40, 32'h8000_0004, 32'h0, 1, 0, 1, 5'd7, 32'h1234_5678, 0,
               0, 1, 0, 1, 0, 4'h0, 32'h0, 32'h0000_0078, 1, 0, 3);
        run_op("lbu5", 32'h40, 32'h8000_0005, 32'h0, 1, 0, 1, 5'd8, 32'h1234_5678, 0,
               0, 1, 0, 1, 0, 4'h0, 32'h0, 32'h0000_0056, 1, 0, 3);
        // sb lane replication and strobe.
        run_op("sb", 32'h160, 32'h8000_0002, 32'h0000_00AB, 0, 1, 0, 5'd0, 32'h0, 0,
               0, 1, 0, 1, 1, 4'b0100, 32'hABAB_ABAB, 32'h0, 0, 0, 3);
        // Misaligned sw: no bus traffic, error at T+1.
        run_op("sw_mis", 32'h80, 32'h8000_0003, 32'h1111_2222, 0, 1, 0, 5'd0, 32'h0, 0,
               0, 1, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 1);
        // Misaligned lw.
        run_op("lw_mis", 32'h20, 32'h8000_0006, 32'h0, 1, 0, 1, 5'd9, 32'h0, 0,
               0, 1, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 1);
        // sw with request and writeback back-pressure.
        run_op("sw_bp", 32'h80, 32'h8000_0008, 32'hCAFE_F00D, 0, 1, 0, 5'd3, 32'h0, 0,
               5, 1, 3, 1, 1, 4'hF, 32'hCAFE_F00D, 32'h0, 0, 0, 8);
        // Timeout with no response: RESP entered at T+2, error at T+2+5.
        run_op("timeout", 32'h20, 32'h8000_0010, 32'h0, 1, 0, 1, 5'd10, 32'h0, 0,
               0, 0, 0, 1, 0, 4'h0, 32'h0, 32'h0, 0, 1, 7);
        // addi result passthrough.
        run_op("addi", 32'h1, 32'h0000_0010, 32'h0, 0, 0, 1, 5'd11, 32'h0, 0,
               0, 1, 0, 0, 0, 4'h0, 32'h0, 32'h0000_0010, 1, 0, 1);
        // Unknown op code with a memory flag.
        run_op("unknown", 32'h3, 32'h0000_0044, 32'h0, 1, 0, 1, 5'd12, 32'h0, 0,
               0, 1, 0, 0, 0, 4'h0, 32'h0, 32'h0000_0044, 0, 1, 1);

        // Reset pulsed in RESP, then a late response arrives.
        inst_type = 32'h20; addr = 32'h8000_0020; read = 1'b1; write = 1'b0;
        reg_wen = 1'b1; rd = 5'd13; mem_req_ready = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 10 && !mem_resp_ready; i++) @(negedge clk);
        chk("rst_resp_reached", mem_resp_ready, 1);
        mem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle("rst_resp");
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h5555_AAAA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle("late_resp");
            chk("late_resp_out_wen", out_wen, 0);
        end
        mem_resp_valid = 1'b0;

        // Reset and in_valid together: nothing is latched.
        inst_type = 32'h1; addr = 32'h0000_0099; read = 1'b0; write = 1'b0;
        reg_wen = 1'b1; rd = 5'd14; in_valid = 1'b1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        chk_idle("rst_inval");
        @(negedge clk);
        chk_idle("rst_inval2");
        chk("rst_inval_out_data", out_data, 0);

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
